// File: rtl/grade_averager_seq.sv
// rtl/grade_averager_seq.sv - three-grade collector with iterative divide-by-3 and pass decision
module grade_averager_seq #(
  parameter int unsigned PASS_MIN = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_grade,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [5:0] sum,
  output logic [3:0] avg,
  output logic [1:0] rem,
  output logic       pass,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIV     = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  count_q;
  logic [3:0]  a_q, b_q, c_q;
  logic [5:0]  sum_q;
  logic [5:0]  residue_q;
  logic [3:0]  quot_q;
  logic [3:0]  avg_q;
  logic [1:0]  rem_q;

  logic        accept;
  logic [5:0]  sum_d;

  assign accept = in_valid && (state_q == COLLECT);
  // A and B are already registered when the third grade arrives
  assign sum_d  = {2'b00, a_q} + {2'b00, b_q} + {2'b00, in_grade};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      count_q   <= 2'd0;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      c_q       <= 4'd0;
      sum_q     <= 6'd0;
      residue_q <= 6'd0;
      quot_q    <= 4'd0;
      avg_q     <= 4'd0;
      rem_q     <= 2'd0;
    end else if (clear) begin
      state_q   <= COLLECT;
      count_q   <= 2'd0;
      residue_q <= 6'd0;
      quot_q    <= 4'd0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            case (count_q)
              2'd0: begin
                a_q     <= in_grade;
                count_q <= 2'd1;
              end
              2'd1: begin
                b_q     <= in_grade;
                count_q <= 2'd2;
              end
              default: begin
                c_q       <= in_grade;
                sum_q     <= sum_d;
                residue_q <= sum_d;
                quot_q    <= 4'd0;
                count_q   <= 2'd0;
                state_q   <= DIV;
              end
            endcase
          end
        end
        DIV: begin
          if (residue_q >= 6'd3) begin
            residue_q <= residue_q - 6'd3;
            quot_q    <= quot_q + 4'd1;
          end else begin
            avg_q   <= quot_q;
            rem_q   <= residue_q[1:0];
            state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q <= COLLECT;
            count_q <= 2'd0;
          end
        end
        default: begin
          state_q <= COLLECT;
          count_q <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == DIV);

  assign A    = a_q;
  assign B    = b_q;
  assign C    = c_q;
  assign sum  = sum_q;
  assign avg  = avg_q;
  assign rem  = rem_q;
  assign pass = (32'(avg_q) >= PASS_MIN);

endmodule

// File: tb/tb_grade_averager_seq.sv
// tb/tb_grade_averager_seq.sv - directed and randomized checks of grade_averager_seq
module tb_grade_averager_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_grade;
  logic [3:0] a_o, b_o, c_o;
  logic [5:0] sum_o;
  logic [3:0] avg_o;
  logic [1:0] rem_o;
  logic       pass_o;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grade_averager_seq #(.PASS_MIN(6)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_grade(in_grade),
    .A(a_o), .B(b_o), .C(c_o), .sum(sum_o), .avg(avg_o), .rem(rem_o),
    .pass(pass_o), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the three grades
  task automatic check_result(input string tag, input int g0, input int g1, input int g2);
    int s;
    s = g0 + g1 + g2;
    check({tag, " A"},    a_o,    g0);
    check({tag, " B"},    b_o,    g1);
    check({tag, " C"},    c_o,    g2);
    check({tag, " sum"},  sum_o,  s);
    check({tag, " avg"},  avg_o,  s / 3);
    check({tag, " rem"},  rem_o,  s % 3);
    check({tag, " pass"}, pass_o, ((s / 3) >= 6) ? 1 : 0);
  endtask

  // Called at a negedge while in COLLECT with count 0
  task automatic do_set(input string tag, input int g0, input int g1, input int g2,
                        input int hold, input bit keep_valid);
    int g[3];
    int lat, busy_cnt, exp_avg;
    g[0] = g0; g[1] = g1; g[2] = g2;
    exp_avg = (g0 + g1 + g2) / 3;
    check({tag, " in_ready before"}, in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_grade = 4'(g[i]);
      @(negedge clk);
    end
    in_valid = keep_valid;
    in_grade = 4'd9;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_avg + 1);
    check({tag, " busy cycles"}, busy_cnt, exp_avg + 1);
    check({tag, " in_ready in OUT"}, in_ready, 0);
    check_result(tag, g0, g1, g2);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, " held out_valid"}, out_valid, 1);
      check_result({tag, " held"}, g0, g1, g2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after hs"}, out_valid, 0);
    check({tag, " in_ready after hs"}, in_ready, 1);
    check({tag, " A after hs"}, a_o, g0);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, r1, r2, rh;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_grade = 4'd0; out_ready = 1'b0;
    #23;
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);
    check("reset pass", pass_o, 0);
    check("reset sum", sum_o, 0);
    check("reset A", a_o, 0);
    #4 rst_n = 1'b1;
    @(negedge clk);

    do_set("s768", 7, 8, 6, 0, 1'b0);
    do_set("s455", 4, 5, 5, 0, 1'b0);
    do_set("s573", 5, 7, 3, 0, 1'b0);
    do_set("s15", 15, 15, 15, 0, 1'b0);
    do_set("s000", 0, 0, 0, 0, 1'b0);

    // Stalled consumer with a grade waiting upstream
    do_set("s666", 6, 6, 6, 5, 1'b1);
    @(negedge clk);
    check("grade9 accepted late", a_o, 9);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear discards accept B", b_o, 6);
    check("clear keeps avg", avg_o, 6);

    // Abort during division
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_grade = 4'd10;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("div busy before clear", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear busy", busy, 0);
    check("clear in_ready", in_ready, 1);
    check("clear keeps sum", sum_o, 30);
    check("clear keeps avg old", avg_o, 6);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      check("cleared set never valid", seen, 0);
    end
    do_set("s111", 1, 1, 1, 0, 1'b0);

    // Asynchronous reset between first and second accept
    in_valid = 1'b1;
    in_grade = 4'd12;
    @(negedge clk);
    in_valid = 1'b0;
    check("partial A", a_o, 12);
    #1 rst_n = 1'b0;
    #1;
    check("async A zero", a_o, 0);
    check("async avg zero", avg_o, 0);
    check("async sum zero", sum_o, 0);
    check("async in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_set("after reset", 3, 4, 5, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      r0 = int'($urandom_range(15, 0));
      r1 = int'($urandom_range(15, 0));
      r2 = int'($urandom_range(15, 0));
      rh = int'($urandom_range(3, 0));
      do_set($sformatf("rand%0d", k), r0, r1, r2, rh, 1'b0);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
